// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch/decode/execute/writeback
// and drives every state-register write enable plus the datapath mux selects.
module multicycle_main_fsm #(
  parameter int DEBUG = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       adr_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECR    = 4'd6;
  localparam logic [3:0] ALUWB    = 4'd7;
  localparam logic [3:0] EXECI    = 4'd8;
  localparam logic [3:0] JAL      = 4'd9;
  localparam logic [3:0] BEQ      = 4'd10;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  logic [3:0] next_state;
  logic       pc_update;
  logic       branch;

  // The parameter only gates simulation tracing outside this file; logic is identical for any value.
  if (DEBUG != 0) begin : g_debug
  end

  // State register with synchronous reset to FETCH
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; unused codes 11-15 recover to FETCH
  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH: next_state = DECODE;
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: next_state = MEMADR;
          OP_RTYPE:          next_state = EXECR;
          OP_ITYPE:          next_state = EXECI;
          OP_JAL:            next_state = JAL;
          OP_BEQ:            next_state = BEQ;
          default:           next_state = FETCH;
        endcase
      end
      MEMADR: begin
        if (op == OP_LOAD) begin
          next_state = MEMREAD;
        end else if (op == OP_STORE) begin
          next_state = MEMWRITE;
        end else begin
          next_state = FETCH;
        end
      end
      MEMREAD:                 next_state = MEMWB;
      EXECR, EXECI, JAL:       next_state = ALUWB;
      MEMWB, MEMWRITE, ALUWB:  next_state = FETCH;
      BEQ:                     next_state = FETCH;
      default:                 next_state = FETCH;
    endcase
  end

  // Moore output decode; everything defaults to 0 so illegal codes drive no enables
  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    illegal_op = 1'b0;
    case (state)
      FETCH: begin
        ir_write   = 1'b1;
        pc_update  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BEQ: illegal_op = 1'b0;
          default:                                               illegal_op = 1'b1;
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD: adr_src = 1'b1;
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      ALUWB: reg_write = 1'b1;
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      default: begin
        pc_update = 1'b0;
      end
    endcase
  end

  // zero is only meaningful while branch is asserted in BEQ
  assign pc_write = pc_update | (branch & zero);

endmodule
